// File: rtl/game_timer_status.sv
// game_timer_status
// Converts elapsed play time from the stopwatch into remaining time against a
// fixed limit, runs the RUN/WARN/CRIT/EXPIRED/WON status machine for display
// and LEDs, and keeps the best completion time across games.
module game_timer_status #(
   parameter int LIMIT_SEC = 1800,  // game time limit, at most 2047
   parameter int WARN_SEC  = 300,   // remaining time at or below which WARN is shown
   parameter int CRIT_SEC  = 60     // remaining time at or below which CRIT is shown
) (
   input  logic        clk_1Hz,
   input  logic        reset,
   input  logic        new_game,
   input  logic        playing_condition,
   input  logic        game_won,
   input  logic [10:0] timer,
   output logic [10:0] remaining,
   output logic [4:0]  rem_minutes,
   output logic [5:0]  rem_seconds,
   output logic [2:0]  state,
   output logic        blink,
   output logic        time_up,
   output logic        best_valid,
   output logic [10:0] best_time,
   output logic        new_record
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_WARN    = 3'd2,
      S_CRIT    = 3'd3,
      S_EXPIRED = 3'd4,
      S_WON     = 3'd5
   } state_t;

   localparam logic [11:0] LIMIT_12  = 12'(LIMIT_SEC);
   localparam logic [11:0] WARN_12   = 12'(WARN_SEC);
   localparam logic [11:0] CRIT_12   = 12'(CRIT_SEC);
   localparam logic [10:0] LIMIT_11  = 11'(LIMIT_SEC);
   localparam logic [4:0]  LIMIT_MIN = 5'(LIMIT_SEC / 60);
   localparam logic [5:0]  LIMIT_S   = 6'(LIMIT_SEC % 60);

   state_t      cur_state, nxt_state;
   logic [11:0] timer_ext;
   logic [11:0] rem;
   logic [10:0] remaining_nxt;
   logic [4:0]  rem_minutes_nxt;
   logic [5:0]  rem_seconds_nxt;
   logic        blink_nxt;
   logic        time_up_nxt;
   logic        best_valid_nxt;
   logic [10:0] best_time_nxt;
   logic        new_record_nxt;

   // Remaining time in 12-bit arithmetic, saturated at zero once the limit is reached.
   assign timer_ext = {1'b0, timer};
   assign rem       = (timer_ext < LIMIT_12) ? (LIMIT_12 - timer_ext) : 12'd0;

   assign state = cur_state;

   // Running-state selection from the remaining time.
   function automatic state_t select_state(input logic [11:0] r);
      if (r == 12'd0)
         return S_EXPIRED;
      else if (r <= CRIT_12)
         return S_CRIT;
      else if (r <= WARN_12)
         return S_WARN;
      else
         return S_RUN;
   endfunction

   // Next-state and next-output logic for the status machine and best-time record.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      nxt_state      = cur_state;
      remaining_nxt  = remaining;
      blink_nxt      = blink;
      best_valid_nxt = best_valid;
      best_time_nxt  = best_time;
      new_record_nxt = 1'b0;

      case (cur_state)
         S_IDLE: begin
            remaining_nxt = LIMIT_11;
            blink_nxt     = 1'b0;
            if (playing_condition && !game_won) begin
               nxt_state     = select_state(rem);
               remaining_nxt = rem[10:0];
               blink_nxt     = (nxt_state == S_EXPIRED);
            end
         end

         S_RUN, S_WARN, S_CRIT: begin
            if (game_won) begin
               // Winning is honoured even while paused; remaining freezes at the winning time.
               nxt_state     = S_WON;
               remaining_nxt = rem[10:0];
               blink_nxt     = 1'b0;
               if (!best_valid || (timer < best_time)) begin
                  best_valid_nxt = 1'b1;
                  best_time_nxt  = timer;
                  new_record_nxt = 1'b1;
               end
            end else if (playing_condition) begin
               nxt_state     = select_state(rem);
               remaining_nxt = rem[10:0];
               case (nxt_state)
                  S_EXPIRED: blink_nxt = 1'b1;
                  S_CRIT:    blink_nxt = (cur_state == S_CRIT) ? ~blink : 1'b0;
                  default:   blink_nxt = 1'b0;
               endcase
            end
            // Paused: everything keeps its defaults, i.e. holds.
         end

         S_EXPIRED: begin
            remaining_nxt = 11'd0;
            blink_nxt     = 1'b1;
         end

         S_WON: begin
            blink_nxt = 1'b0;
         end

         default: begin
            nxt_state     = S_IDLE;
            remaining_nxt = LIMIT_11;
            blink_nxt     = 1'b0;
         end
      endcase

      // A new game overrides everything except the best-time record.
      if (new_game) begin
         nxt_state      = S_IDLE;
         remaining_nxt  = LIMIT_11;
         blink_nxt      = 1'b0;
         new_record_nxt = 1'b0;
         best_valid_nxt = best_valid;
         best_time_nxt  = best_time;
      end

      time_up_nxt     = (nxt_state == S_EXPIRED);
      rem_minutes_nxt = 5'(remaining_nxt / 11'd60);
      rem_seconds_nxt = 6'(remaining_nxt % 11'd60);
   end

   // State and output registers; reset also wipes the best-time record.
   always_ff @(posedge clk_1Hz or posedge reset) begin
      if (reset) begin
         cur_state   <= S_IDLE;
         remaining   <= LIMIT_11;
         rem_minutes <= LIMIT_MIN;
         rem_seconds <= LIMIT_S;
         blink       <= 1'b0;
         time_up     <= 1'b0;
         best_valid  <= 1'b0;
         best_time   <= 11'd0;
         new_record  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         cur_state   <= nxt_state;
         remaining   <= remaining_nxt;
         rem_minutes <= rem_minutes_nxt;
         rem_seconds <= rem_seconds_nxt;
         blink       <= blink_nxt;
         time_up     <= time_up_nxt;
         best_valid  <= best_valid_nxt;
         best_time   <= best_time_nxt;
         new_record  <= new_record_nxt;
      end
   end

endmodule

// File: tb/tb_game_timer_status.sv
// Testbench for game_timer_status: table of stimulus/expectation records fed
// through a scoreboard queue, plus hand-written async-reset and
// win-at-the-limit sequences.
module tb_game_timer_status;

   localparam int ST_IDLE = 0, ST_RUN = 1, ST_WARN = 2, ST_CRIT = 3, ST_EXP = 4, ST_WON = 5;

   typedef enum {BL_VAL, BL_ANY, BL_TOG} bl_mode_t;

   typedef struct {
      logic        ng;
      logic        pc;
      logic        gw;
      logic [10:0] tmr;
      logic [2:0]  st;
      logic [10:0] rem;
      bit          chk_rem;
      bl_mode_t    blm;
      logic        bl;
      logic        tu;
      logic        bv;
      logic [10:0] bt;
      logic        nr;
   } vec_t;

   logic        clk_1Hz = 1'b0;
   logic        reset;
   logic        new_game;
   logic        playing_condition;
   logic        game_won;
   logic [10:0] timer;
   logic [10:0] remaining;
   logic [4:0]  rem_minutes;
   logic [5:0]  rem_seconds;
   logic [2:0]  state;
   logic        blink;
   logic        time_up;
   logic        best_valid;
   logic [10:0] best_time;
   logic        new_record;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_blink = 1'b0;
   vec_t vecs[$];
   vec_t sb[$];

   game_timer_status dut (
      .clk_1Hz          (clk_1Hz),
      .reset            (reset),
      .new_game         (new_game),
      .playing_condition(playing_condition),
      .game_won         (game_won),
      .timer            (timer),
      .remaining        (remaining),
      .rem_minutes      (rem_minutes),
      .rem_seconds      (rem_seconds),
      .state            (state),
      .blink            (blink),
      .time_up          (time_up),
      .best_valid       (best_valid),
      .best_time        (best_time),
      .new_record       (new_record)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input int ng, input int pc, input int gw, input int tmr,
                               input int st, input int rem, input bit chk_rem,
                               input bl_mode_t blm, input int bl, input int tu,
                               input int bv, input int bt, input int nr);
      vec_t v;
      v.ng = ng[0]; v.pc = pc[0]; v.gw = gw[0]; v.tmr = 11'(tmr);
      v.st = 3'(st); v.rem = 11'(rem); v.chk_rem = chk_rem; v.blm = blm;
      v.bl = bl[0]; v.tu = tu[0]; v.bv = bv[0]; v.bt = 11'(bt); v.nr = nr[0];
      return v;
   endfunction

   // Drive one tick of stimulus, queue its expectation, then compare after the edge.
   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      logic exp_b;
      @(negedge clk_1Hz);
      new_game          = v.ng;
      playing_condition = v.pc;
      game_won          = v.gw;
      timer             = v.tmr;
      sb.push_back(v);
      @(posedge clk_1Hz);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, " state"}, 32'(state), 32'(e.st));
      if (e.chk_rem) begin
         check({tag, " remaining"},   32'(remaining),   32'(e.rem));
         check({tag, " rem_minutes"}, 32'(rem_minutes), 32'(e.rem) / 60);
         check({tag, " rem_seconds"}, 32'(rem_seconds), 32'(e.rem) % 60);
      end
      case (e.blm)
         BL_VAL: check({tag, " blink"}, 32'(blink), 32'(e.bl));
         BL_TOG: begin
            exp_b = ~prev_blink;
            check({tag, " blink toggle"}, 32'(blink), 32'(exp_b));
         end
         default: ;
      endcase
      check({tag, " time_up"},    32'(time_up),    32'(e.tu));
      check({tag, " best_valid"}, 32'(best_valid), 32'(e.bv));
      check({tag, " best_time"},  32'(best_time),  32'(e.bt));
      check({tag, " new_record"}, 32'(new_record), 32'(e.nr));
      prev_blink = blink;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " state"},       32'(state),       ST_IDLE);
      check({tag, " remaining"},   32'(remaining),   1800);
      check({tag, " rem_minutes"}, 32'(rem_minutes), 30);
      check({tag, " rem_seconds"}, 32'(rem_seconds), 0);
      check({tag, " blink"},       32'(blink),       0);
      check({tag, " time_up"},     32'(time_up),     0);
      check({tag, " new_record"},  32'(new_record),  0);
      check({tag, " best_valid"},  32'(best_valid),  0);
      check({tag, " best_time"},   32'(best_time),   0);
   endtask

   initial begin
      reset = 1'b1; new_game = 1'b0; playing_condition = 1'b0; game_won = 1'b0; timer = 11'd0;

      //          ng pc gw timer  state    rem  chk  blink     tu bv  bt  nr
      // Start and count down through RUN.
      vecs.push_back(mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0,    1, ST_RUN, 1799, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0,    2, ST_RUN, 1798, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 1499, ST_RUN,  301, 1, BL_VAL, 0, 0, 0,   0, 0));
      // WARN threshold boundary, then a three-tick pause with timer held.
      vecs.push_back(mk(0, 1, 0, 1500, ST_WARN, 300, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 0, 0, 1500, ST_WARN, 300, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 0, 0, 1500, ST_WARN, 300, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 0, 0, 1500, ST_WARN, 300, 1, BL_VAL, 0, 0, 0,   0, 0));
      // CRIT boundary and blink toggling, then back up to WARN.
      vecs.push_back(mk(0, 1, 0, 1739, ST_WARN,  61, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 1740, ST_CRIT,  60, 1, BL_ANY, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 1741, ST_CRIT,  59, 1, BL_TOG, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 1742, ST_CRIT,  58, 1, BL_TOG, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0, 1700, ST_WARN, 100, 1, BL_VAL, 0, 0, 0,   0, 0));
      // Expiry, sticky across the stopwatch wrap and five further ticks.
      vecs.push_back(mk(0, 1, 0, 1800, ST_EXP,    0, 1, BL_VAL, 1, 1, 0,   0, 0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 1, 0,  0, ST_EXP,    0, 1, BL_VAL, 1, 1, 0,   0, 0));
      // New game; game_won held in IDLE does not start play.
      vecs.push_back(mk(1, 0, 0,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 1,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 0,   0, 0));
      // First win at 900: new record.
      vecs.push_back(mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 0,  900, ST_RUN,  900, 1, BL_VAL, 0, 0, 0,   0, 0));
      vecs.push_back(mk(0, 1, 1,  900, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 900, 1));
      vecs.push_back(mk(0, 1, 1,  900, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 900, 0));
      // Slower win at 950: no record.
      vecs.push_back(mk(1, 0, 0,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 0,  950, ST_RUN,  850, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 1,  950, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 900, 0));
      // Faster win at 700: new record.
      vecs.push_back(mk(1, 0, 0,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 0,  700, ST_RUN, 1100, 1, BL_VAL, 0, 0, 1, 900, 0));
      vecs.push_back(mk(0, 1, 1,  700, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 700, 1));
      vecs.push_back(mk(0, 1, 1,  700, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 700, 0));
      // Tie at 700: not a record.
      vecs.push_back(mk(1, 0, 0,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 1, 700, 0));
      vecs.push_back(mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 1, 700, 0));
      vecs.push_back(mk(0, 1, 1,  700, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 700, 0));
      vecs.push_back(mk(1, 0, 0,    0, ST_IDLE, 1800, 1, BL_VAL, 0, 0, 1, 700, 0));

      // Reset values while reset is held, then release away from the clock edge.
      repeat (2) @(posedge clk_1Hz);
      #1;
      check_reset_values("reset_held");
      @(negedge clk_1Hz);
      reset = 1'b0;
      @(posedge clk_1Hz);
      #1;
      check_reset_values("after_release");

      for (int i = 0; i < vecs.size(); i++)
         apply($sformatf("vec%0d", i), vecs[i]);

      // Asynchronous reset in the middle of CRIT, with new_game also high.
      apply("crit_a", mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 1, 700, 0));
      apply("crit_b", mk(0, 1, 0, 1750, ST_CRIT,  50, 1, BL_ANY, 0, 0, 1, 700, 0));
      @(negedge clk_1Hz);
      #2;
      new_game = 1'b1;
      reset    = 1'b1;
      #1;
      check_reset_values("async_reset");
      @(negedge clk_1Hz);
      reset    = 1'b0;
      new_game = 1'b0;
      playing_condition = 1'b0;

      // Win on the same tick that time runs out: WON takes priority over EXPIRED.
      apply("lim_a", mk(0, 1, 0,    0, ST_RUN, 1800, 1, BL_VAL, 0, 0, 0,    0, 0));
      apply("lim_b", mk(0, 1, 1, 1800, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 1800, 1));
      apply("lim_c", mk(0, 1, 1, 1800, ST_WON,    0, 0, BL_VAL, 0, 0, 1, 1800, 0));

      check("scoreboard drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
